// File: rtl/dac_sample_sequencer.sv
// Buffers channel-tagged 10-bit samples and releases one per sample period to the Mercury2 DAC
// wrapper. Define DAC_SEQ_LOOP_EN to turn the buffer into a looping waveform memory.
module dac_sample_sequencer #(
    parameter int unsigned SamplePeriod = 500,
    parameter int unsigned FifoDepth    = 16,
    parameter int unsigned AddrBits     = 4
) (
    input  logic                clk_50MHZ,
    input  logic                reset,
    input  logic                run,
    input  logic                wr_en,
    input  logic                wr_channel,
    input  logic [9:0]          wr_data,
    output logic                full,
    output logic                empty,
    output logic [AddrBits:0]   count,
    input  logic                dac_busy,
    output logic                dac_trigger,
    output logic                dac_channel,
    output logic [9:0]          dac_din,
    output logic                underrun,
    output logic                overflow,
    output logic                late
);

    localparam int unsigned TimerBits = $clog2(SamplePeriod);
    localparam logic [TimerBits-1:0] TickValue = TimerBits'(SamplePeriod - 1);
    localparam logic [AddrBits:0] DepthValue = (AddrBits + 1)'(FifoDepth);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StTrig,
        StGuard,
        StWait
    } state_e;

    state_e               state_q;
    logic [TimerBits-1:0] timer_q, timer_d;
    logic                 run_q;
    logic [AddrBits-1:0]  wptr_q, wptr_d;
    logic [AddrBits-1:0]  rptr_q, rptr_d;
    logic [AddrBits:0]    count_q, count_d;
    logic [10:0]          mem_q [FifoDepth];
    logic [9:0]           din_q;
    logic                 chan_q;
    logic                 underrun_q, overflow_q, late_q;

    logic run_rise, tick, push, pop, wr_drop;

    assign run_rise = run & ~run_q;
    assign tick     = run & (timer_q == TickValue);
    assign full     = (count_q == DepthValue);
    assign empty    = (count_q == '0);
    assign pop      = (state_q == StIdle) & tick & ~empty;

`ifdef DAC_SEQ_LOOP_EN
    // The buffer is waveform memory while running, so host writes only land when stopped.
    assign push    = wr_en & ~run & ~full;
    assign wr_drop = wr_en & ~run & full;
`else
    assign push    = wr_en & ~full;
    assign wr_drop = wr_en & full;
`endif

    always_comb begin
        timer_d = '0;
        if (run) begin
            timer_d = tick ? '0 : timer_q + 1'b1;
        end
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
`ifdef DAC_SEQ_LOOP_EN
        count_d = push ? count_q + 1'b1 : count_q;
        rptr_d  = rptr_q;
        if (run_rise) begin
            rptr_d = '0;
        end else if (pop) begin
            rptr_d = ({1'b0, rptr_q} == count_q - 1'b1) ? '0 : rptr_q + 1'b1;
        end
`else
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
`endif
    end

    always_ff @(posedge clk_50MHZ) begin
        if (push) begin
            mem_q[wptr_q] <= {wr_channel, wr_data};
        end
    end

    always_ff @(posedge clk_50MHZ) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            run_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            din_q      <= '0;
            chan_q     <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            run_q   <= run;
            timer_q <= timer_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;

            if (run_rise) begin
                underrun_q <= 1'b0;
                overflow_q <= 1'b0;
                late_q     <= 1'b0;
            end
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end
            // Ticks that arrive mid-sequence are dropped, not queued.
            if (tick && state_q != StIdle) begin
                late_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (pop) begin
                        {chan_q, din_q} <= mem_q[rptr_q];
                        state_q         <= StSetup;
                    end else if (tick) begin
                        underrun_q <= 1'b1;
                    end
                end
                StSetup: state_q <= StTrig;
                StTrig:  state_q <= StGuard;
                // Guard cycle skips the wrapper's registered Busy, which lags the trigger.
                StGuard: state_q <= StWait;
                StWait: begin
                    if (!dac_busy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign count       = count_q;
    assign dac_trigger = (state_q == StTrig);
    assign dac_din     = din_q;
    assign dac_channel = chan_q;
    assign underrun    = underrun_q;
    assign overflow    = overflow_q;
    assign late        = late_q;

endmodule
